sweep_ctrl: RTL

- Sequencer that drives a 6-bit memory address through a programmed burst of reads (start address + count), with downstream stall, abort and completion handshake.
- Sits between the command source and a 64-word synchronous-read memory.
- Replaces free-running address counting with a bounded, wrapping sweep.
- Tracks in-flight reads through the memory's read latency so `done` aligns after the last data.

---
 rtl/sweep_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sweep_ctrl.sv
// Bounded, wrapping read sweep over a synchronous-read memory.
// Issues start_addr..start_addr+count-1 reads, then drains in-flight data before pulsing done.
module sweep_ctrl #(
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   count,
   input  logic              hold,
   input  logic              abort,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_en,
   output logic              data_valid,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W:0]   issued
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int              DCW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(RD_LAT - 1);
   localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   remaining_reg;
   logic [ADDR_W:0]   issued_reg;
   logic [DCW-1:0]    drain_cnt_reg;
   logic              aborted_reg;
   logic              done_reg;
   logic [RD_LAT-1:0] dv_pipe_reg;

   logic rd_fire;
   logic load_cmd;
   logic zero_cmd;
   logic last_read;
   logic abort_run;
   logic drain_exit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (load_cmd) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (abort_run || last_read) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Per-state decode; everything the datapath reacts to is derived here.
   always_comb begin
      rd_fire    = 1'b0;
      load_cmd   = 1'b0;
      zero_cmd   = 1'b0;
      last_read  = 1'b0;
      abort_run  = 1'b0;
      drain_exit = 1'b0;
      case (state_reg)
         IDLE: begin
            load_cmd = start && (count != '0);
            zero_cmd = start && (count == '0);
         end
         RUN: begin
            rd_fire   = ~hold & ~abort;
            abort_run = abort;
            last_read = rd_fire && (remaining_reg == ONE);
         end
         DRAIN: begin
            drain_exit = (drain_cnt_reg == DRAIN_LAST);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg      <= '0;
         remaining_reg <= '0;
         issued_reg    <= '0;
         aborted_reg   <= 1'b0;
         done_reg      <= 1'b0;
         drain_cnt_reg <= '0;
      end else begin
         done_reg <= zero_cmd | drain_exit;

         if (load_cmd) begin
            addr_reg      <= start_addr;
            remaining_reg <= count;
            issued_reg    <= '0;
            aborted_reg   <= 1'b0;
         end else if (zero_cmd) begin
            issued_reg    <= '0;
            aborted_reg   <= 1'b0;
         end else if (rd_fire) begin
            // Address arithmetic is ADDR_W wide, so 2^ADDR_W-1 wraps to 0.
            addr_reg      <= addr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            issued_reg    <= issued_reg + 1'b1;
         end else if (abort_run) begin
            aborted_reg   <= 1'b1;
         end

         if (state_reg == DRAIN) begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
         end else begin
            drain_cnt_reg <= '0;
         end
      end
   end

   // Read-strobe delay line matching the memory latency.
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_dv
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) begin
                  dv_pipe_reg[gi] <= 1'b0;
               end else begin
                  dv_pipe_reg[gi] <= rd_fire;
               end
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (reset) begin
                  dv_pipe_reg[gi] <= 1'b0;
               end else begin
                  dv_pipe_reg[gi] <= dv_pipe_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign addr       = addr_reg;
   assign rd_en      = rd_fire;
   assign data_valid = dv_pipe_reg[RD_LAT-1];
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign aborted    = aborted_reg;
   assign issued     = issued_reg;

endmodule
